// File: rtl/boot_loader_if.sv
// Byte-stream and instruction-memory bundle for the boot loader.
// slave  : the loader side (consumes bytes, drives memory writes and status).
// master : the environment side (byte source, memory, cpu control).
interface boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_enable;
    logic              busy;
    logic              done;
    logic              err;

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output cpu_enable, busy, done, err
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_enable, busy, done, err
    );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: receives a 16-bit big-endian word count followed by big-endian
// 32-bit instruction words over a valid/ready byte stream, writes them into
// instruction memory and keeps the cpu stalled until the image is complete.
// Optional feature macro: CHECKSUM_EN -- adds a trailing XOR checksum byte
// that must match the XOR of all header and payload bytes.
module boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    boot_loader_if.slave bus
);

`ifdef CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_LOAD = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;
    localparam state_t S_FINAL = S_CSUM;
`else
    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_LOAD = 3'd1,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;
    localparam state_t S_FINAL = S_DONE;
`endif

    // Largest legal word count is the full memory (2**ADDR_W words).
    localparam logic [16:0]   CAPACITY = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] WORD_ONE = (ADDR_W + 1)'(1);

    state_t            r_state,        w_state_nxt;
    logic [1:0]        r_byte_cnt,     w_byte_cnt_nxt;
    logic [ADDR_W:0]   r_word_cnt,     w_word_cnt_nxt;
    logic [ADDR_W:0]   r_n,            w_n_nxt;
    logic [7:0]        r_hdr_hi,       w_hdr_hi_nxt;
    logic [23:0]       r_buf,          w_buf_nxt;
    logic              r_in_ready,     w_in_ready_nxt;
    logic              r_imem_we,      w_imem_we_nxt;
    logic [ADDR_W-1:0] r_imem_addr,    w_imem_addr_nxt;
    logic [31:0]       r_imem_wdata,   w_imem_wdata_nxt;
    logic              r_cpu_enable,   w_cpu_enable_nxt;
    logic              r_busy,         w_busy_nxt;
    logic              r_done,         w_done_nxt;
    logic              r_err,          w_err_nxt;
`ifdef CHECKSUM_EN
    logic [7:0]        r_csum,         w_csum_nxt;
`endif

    logic              w_xfer;
    logic [15:0]       w_hdr_n;

    // A byte moves only when the registered ready is presented together with valid.
    assign w_xfer  = bus.in_valid & r_in_ready;
    assign w_hdr_n = {r_hdr_hi, bus.in_data};

    // State register and all registered datapath/outputs; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_HDR;
            r_byte_cnt   <= 2'd0;
            r_word_cnt   <= '0;
            r_n          <= '0;
            r_hdr_hi     <= 8'd0;
            r_buf        <= 24'd0;
            r_in_ready   <= 1'b0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= 32'd0;
            r_cpu_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
            r_n          <= w_n_nxt;
            r_hdr_hi     <= w_hdr_hi_nxt;
            r_buf        <= w_buf_nxt;
            r_in_ready   <= w_in_ready_nxt;
            r_imem_we    <= w_imem_we_nxt;
            r_imem_addr  <= w_imem_addr_nxt;
            r_imem_wdata <= w_imem_wdata_nxt;
            r_cpu_enable <= w_cpu_enable_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
`ifdef CHECKSUM_EN
            r_csum       <= w_csum_nxt;
`endif
        end
    end

    // Next-state, datapath and output decode; outputs follow the next state so they are registered.
    always_comb begin
        w_state_nxt      = r_state;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_word_cnt_nxt   = r_word_cnt;
        w_n_nxt          = r_n;
        w_hdr_hi_nxt     = r_hdr_hi;
        w_buf_nxt        = r_buf;
        w_imem_we_nxt    = 1'b0;
        w_imem_addr_nxt  = r_imem_addr;
        w_imem_wdata_nxt = r_imem_wdata;
`ifdef CHECKSUM_EN
        w_csum_nxt       = r_csum;
`endif

        case (r_state)
            S_HDR: begin
                if (w_xfer) begin
`ifdef CHECKSUM_EN
                    w_csum_nxt = r_csum ^ bus.in_data;
`endif
                    if (r_byte_cnt == 2'd0) begin
                        w_hdr_hi_nxt   = bus.in_data;
                        w_byte_cnt_nxt = 2'd1;
                    end else begin
                        w_byte_cnt_nxt = 2'd0;
                        if (w_hdr_n == 16'd0) begin
                            w_state_nxt = S_FINAL;
                        end else if ({1'b0, w_hdr_n} > CAPACITY) begin
                            w_state_nxt = S_ERR;
                        end else begin
                            w_n_nxt     = w_hdr_n[ADDR_W:0];
                            w_state_nxt = S_LOAD;
                        end
                    end
                end else begin
                    w_state_nxt = S_HDR;
                end
            end
            S_LOAD: begin
                // word_cnt==N only during the cycle of the last write pulse.
                if (r_word_cnt == r_n) begin
                    w_state_nxt = S_FINAL;
                end else if (w_xfer) begin
`ifdef CHECKSUM_EN
                    w_csum_nxt = r_csum ^ bus.in_data;
`endif
                    w_byte_cnt_nxt = r_byte_cnt + 2'd1;
                    w_buf_nxt      = {r_buf[15:0], bus.in_data};
                    if (r_byte_cnt == 2'd3) begin
                        w_imem_we_nxt    = 1'b1;
                        w_imem_addr_nxt  = r_word_cnt[ADDR_W-1:0];
                        w_imem_wdata_nxt = {r_buf, bus.in_data};
                        w_word_cnt_nxt   = r_word_cnt + WORD_ONE;
                    end else begin
                        w_imem_we_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
`ifdef CHECKSUM_EN
            S_CSUM: begin
                if (w_xfer) begin
                    w_state_nxt = (bus.in_data == r_csum) ? S_DONE : S_ERR;
                end else begin
                    w_state_nxt = S_CSUM;
                end
            end
`endif
            S_DONE:  w_state_nxt = S_DONE;
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_ERR;
        endcase

        w_in_ready_nxt   = 1'b0;
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        w_err_nxt        = 1'b0;
        w_cpu_enable_nxt = 1'b0;
        case (w_state_nxt)
            S_HDR: begin
                w_in_ready_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
            end
            S_LOAD: begin
                // Drop ready together with the final write pulse.
                w_in_ready_nxt = (w_word_cnt_nxt != w_n_nxt);
                w_busy_nxt     = 1'b1;
            end
`ifdef CHECKSUM_EN
            S_CSUM: begin
                w_in_ready_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
            end
`endif
            S_DONE: begin
                w_done_nxt       = 1'b1;
                w_cpu_enable_nxt = 1'b1;
            end
            S_ERR: begin
                w_err_nxt = 1'b1;
            end
            default: begin
                w_err_nxt = 1'b1;
            end
        endcase
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign bus.cpu_enable = r_cpu_enable;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader (ADDR_W=8). Expected memory writes are
// derived from the byte image itself: word i = bytes 4i..4i+3, big-endian, at address i.
module tb_boot_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0]  img_q[$];
    logic [39:0] obs_q[$];

    boot_loader_if #(.ADDR_W(8)) bus ();

    boot_loader #(.ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Record every memory write pulse as {addr, data}.
    always @(posedge clk) begin
        if (bus.imem_we === 1'b1) obs_q.push_back({bus.imem_addr, bus.imem_wdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(2, 0));
    endfunction

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_outs", {bus.done, bus.err, bus.cpu_enable, bus.imem_we}, 4'b0000);
        reset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready_busy", {bus.in_ready, bus.busy}, 2'b11);
        obs_q.delete();
    endtask

    // Offer one byte after 'gap' idle cycles; returns #1 after the handshake edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 64) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 64) begin
            check("handshake_timeout", 64'(waited), 64'd0);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        int nw;
        logic [39:0] exp;
        nw = img_q.size() / 4;
        check({tag, "_wcount"}, 64'(obs_q.size()), 64'(nw));
        for (int i = 0; i < nw && i < obs_q.size(); i++) begin
            exp = (40'(i % 256) << 32) | (40'(img_q[4*i]) << 24) | (40'(img_q[4*i+1]) << 16)
                | (40'(img_q[4*i+2]) << 8) | 40'(img_q[4*i+3]);
            check({tag, "_write"}, obs_q[i], exp);
        end
    endtask

    // Load a complete image whose payload is img_q and check the write and release timing.
    task automatic run_image(input logic [15:0] n, input int mode, input string tag);
        logic [7:0] x;
        x = n[15:8] ^ n[7:0];
        foreach (img_q[i]) x = x ^ img_q[i];
        send_byte(n[15:8], pick_gap(mode));
        send_byte(n[7:0], pick_gap(mode));
        for (int i = 0; i < img_q.size(); i++) send_byte(img_q[i], pick_gap(mode));
        check({tag, "_last_we"}, {bus.imem_we, bus.in_ready, bus.cpu_enable}, 3'b100);
        check({tag, "_last_addr"}, bus.imem_addr, 8'(n - 16'd1));
        @(posedge clk); #1;
        check({tag, "_we_drop"}, bus.imem_we, 1'b0);
`ifdef CHECKSUM_EN
        check({tag, "_csum_wait"}, {bus.in_ready, bus.busy, bus.done}, 3'b110);
        send_byte(x, 0);
`endif
        check({tag, "_released"}, {bus.done, bus.cpu_enable, bus.busy, bus.in_ready, bus.err}, 5'b11000);
        check_writes(tag);
    endtask

    initial begin
        int nsz;
        int nwr;
        logic [15:0] n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;

        // Directed image, back-to-back bytes.
        do_reset();
        img_q = '{8'h3C, 8'h01, 8'h00, 8'h10, 8'h20, 8'h22, 8'h00, 8'h05};
        run_image(16'd2, 0, "img2");
        // Bytes offered after DONE are ignored.
        nwr = obs_q.size();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        repeat (5) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("after_done", {bus.in_ready, bus.done, bus.cpu_enable, bus.imem_we}, 4'b0110);
        check("after_done_nowr", 64'(obs_q.size()), 64'(nwr));

        // Same image, valid toggling every other cycle.
        do_reset();
        run_image(16'd2, 1, "img2_gap");

        // Random images with random idle cycles.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            nsz = int'($urandom_range(6, 1));
            img_q.delete();
            for (int i = 0; i < 4 * nsz; i++) img_q.push_back(8'($urandom));
            run_image(16'(nsz), 2, "rand");
        end

        // Full-capacity image (256 words).
        do_reset();
        img_q.delete();
        for (int i = 0; i < 1024; i++) img_q.push_back(8'($urandom));
        run_image(16'd256, 0, "full");

        // Empty image.
        do_reset();
        img_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef CHECKSUM_EN
        check("n0_csum_wait", {bus.in_ready, bus.busy}, 2'b11);
        send_byte(8'h00, 0);
`endif
        check("n0_done", {bus.done, bus.cpu_enable, bus.busy, bus.in_ready, bus.err}, 5'b11000);
        @(posedge clk); #1;
        check("n0_nowr", 64'(obs_q.size()), 64'd0);

        // Oversize header.
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check("oversize_err", {bus.err, bus.cpu_enable, bus.in_ready, bus.busy, bus.done}, 5'b10000);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (4) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("after_err", {bus.err, bus.in_ready, bus.imem_we}, 3'b100);
        check("after_err_nowr", 64'(obs_q.size()), 64'd0);

        // Header exactly at capacity is accepted.
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        check("cap_accept", {bus.err, bus.busy, bus.in_ready}, 3'b011);

        // Reset after 6 payload bytes, then a fresh one-word image.
        do_reset();
        img_q = '{8'h3C, 8'h01, 8'h00, 8'h10, 8'h20, 8'h22};
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 6; i++) send_byte(img_q[i], 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_outs", {bus.in_ready, bus.busy, bus.imem_we, bus.done, bus.cpu_enable}, 5'b00000);
        img_q = '{8'h3C, 8'h01, 8'h00, 8'h10};
        check_writes("midrst");
        do_reset();
        img_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_image(16'd1, 0, "after_rst");

`ifdef CHECKSUM_EN
        // Wrong checksum byte rejects the image.
        do_reset();
        img_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        n = 16'd1;
        send_byte(n[15:8], 0);
        send_byte(n[7:0], 0);
        for (int i = 0; i < 4; i++) send_byte(img_q[i], 0);
        @(posedge clk); #1;
        send_byte(8'h00, 0);
        check("bad_csum", {bus.err, bus.cpu_enable, bus.done, bus.in_ready}, 4'b1000);
`else
        n = 16'd0;
        check("final_idle", {bus.imem_we, n[0]}, 2'b00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
